// File: rtl/ec_ctrl_pkg.sv
// ec_ctrl_pkg: shared state encoding, K/M limits and config legality check for the EC controller
package ec_ctrl_pkg;
  localparam int unsigned EC_K_MIN = 2;
  localparam int unsigned EC_K_MAX = 128;
  localparam int unsigned EC_M_MIN = 2;
  localparam int unsigned EC_M_MAX = 128;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CALC, ST_DRAIN, ST_DONE} eng_seq_st_t;
  function automatic logic cfg_legal(input int unsigned k, input int unsigned m, input int unsigned beats,
                                     input int unsigned k_min = EC_K_MIN, input int unsigned k_max = EC_K_MAX,
                                     input int unsigned m_min = EC_M_MIN, input int unsigned m_max = EC_M_MAX);
    return k >= k_min && k <= k_max && m >= m_min && m <= m_max && beats != 0;
  endfunction
endpackage

// File: rtl/eng_valid_pipe.sv
// eng_valid_pipe: tracks engine result validity through its latency, freezing with the engine
module eng_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic hold_i,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o,
  output logic empty_o
);
  logic [DEPTH-1:0] pipe_q, pipe_d;
  always_comb pipe_d = clr_i ? '0 : hold_i ? pipe_q : (pipe_q << 1) | DEPTH'(in_i);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pipe_q <= '0;
    else pipe_q <= pipe_d;
  assign out_o = pipe_q[DEPTH-1];
  // empty looks at the post-shift value so the final result is written before DONE
  assign empty_o = ~|pipe_d;
endmodule

// File: rtl/eng_seq_ctrl.sv
// eng_seq_ctrl: walks bitmatrix rows per input beat, throttled by buffer state, then drains and signals done
module eng_seq_ctrl
  import ec_ctrl_pkg::*;
#(
  parameter int K_MAX      = 128,
  parameter int K_MIN      = 2,
  parameter int M_MAX      = 128,
  parameter int M_MIN      = 2,
  parameter int BEAT_W     = 16,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [$clog2(K_MAX+1)-1:0] cfg_k,
  input  logic [$clog2(M_MAX+1)-1:0] cfg_m,
  input  logic [BEAT_W-1:0]          cfg_beats,
  input  logic                       inbuff_empty,
  input  logic                       outbuff_full,
  output logic                       cfg_wr_en,
  output logic                       inbuff_rd_en,
  output logic                       bm_rd_en,
  output logic [$clog2(M_MAX)-1:0]   bm_rd_addr,
  output logic                       eng_calc_en,
  output logic                       eng_hold,
  output logic                       eng_rstn,
  output logic                       outbuff_wr_en,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);
  localparam int MW = $clog2(M_MAX+1);
  localparam int AW = $clog2(M_MAX);
  eng_seq_st_t       state_q, state_d;
  logic [AW-1:0]     row_q, row_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beats_q, beats_d;
  logic [MW-1:0]     m_q, m_d;
  logic              cfg_err_q, cfg_err_d;
  logic              adv, last_row, last_beat, legal, pipe_out, pipe_empty;
  assign legal     = cfg_legal(32'(cfg_k), 32'(cfg_m), 32'(cfg_beats), K_MIN, K_MAX, M_MIN, M_MAX);
  assign last_row  = MW'(row_q) == m_q - MW'(1);
  assign last_beat = beat_q == beats_q - BEAT_W'(1);
  // a new beat needs a pop, later rows of a popped beat only need output room
  assign adv = state_q == ST_CALC && !abort && !outbuff_full && (row_q != '0 || !inbuff_empty);
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    beat_d    = beat_q;
    m_d       = m_q;
    beats_d   = beats_q;
    cfg_err_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      row_d   = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = start && legal ? ST_LOAD : ST_IDLE;
          cfg_err_d = start && !legal;
        end
        ST_LOAD: begin
          m_d     = cfg_m;
          beats_d = cfg_beats;
          row_d   = '0;
          beat_d  = '0;
          state_d = ST_CALC;
        end
        ST_CALC: if (adv) begin
          row_d   = last_row ? '0 : row_q + AW'(1);
          beat_d  = last_row ? beat_q + BEAT_W'(1) : beat_q;
          state_d = last_row && last_beat ? ST_DRAIN : ST_CALC;
        end
        ST_DRAIN: state_d = pipe_empty ? ST_DONE : ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      beat_q    <= '0;
      m_q       <= '0;
      beats_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      beat_q    <= beat_d;
      m_q       <= m_d;
      beats_q   <= beats_d;
      cfg_err_q <= cfg_err_d;
    end
  eng_valid_pipe #(.DEPTH(PIPE_DEPTH)) u_pipe (
    .clk    (clk),
    .rstn   (rstn),
    .hold_i (outbuff_full),
    .clr_i  (abort),
    .in_i   (eng_calc_en),
    .out_o  (pipe_out),
    .empty_o(pipe_empty)
  );
  assign cfg_wr_en     = state_q == ST_IDLE;
  assign busy          = state_q == ST_LOAD || state_q == ST_CALC || state_q == ST_DRAIN;
  assign eng_rstn      = state_q != ST_IDLE && !abort;
  assign eng_hold      = state_q != ST_IDLE && outbuff_full;
  assign bm_rd_en      = adv;
  assign eng_calc_en   = adv;
  assign bm_rd_addr    = adv ? row_q : '0;
  assign inbuff_rd_en  = adv && row_q == '0;
  assign outbuff_wr_en = pipe_out && !outbuff_full;
  assign done          = state_q == ST_DONE && !abort;
  assign cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_eng_seq_ctrl.sv
// tb_eng_seq_ctrl: directed scenario tests of the sequencing controller against hand-computed cycle counts
module tb_eng_seq_ctrl;
  logic       clk, rstn, start, abort, inbuff_empty, outbuff_full;
  logic [7:0] cfg_k, cfg_m;
  logic [15:0] cfg_beats;
  logic       cfg_wr_en, inbuff_rd_en, bm_rd_en, eng_calc_en, eng_hold, eng_rstn;
  logic       outbuff_wr_en, busy, done, cfg_err;
  logic [6:0] bm_rd_addr;
  logic [16:0] outs;
  localparam logic [16:0] RST_OUTS = 17'h10000;
  int checks = 0, errors = 0;
  int r_bm, r_wr, r_fw, r_lw, r_dc, r_aerr, r_herr, r_serr, r_np;
  int r_pc [8];

  eng_seq_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .cfg_k(cfg_k), .cfg_m(cfg_m),
    .cfg_beats(cfg_beats), .inbuff_empty(inbuff_empty), .outbuff_full(outbuff_full),
    .cfg_wr_en(cfg_wr_en), .inbuff_rd_en(inbuff_rd_en), .bm_rd_en(bm_rd_en), .bm_rd_addr(bm_rd_addr),
    .eng_calc_en(eng_calc_en), .eng_hold(eng_hold), .eng_rstn(eng_rstn), .outbuff_wr_en(outbuff_wr_en),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  assign outs = {cfg_wr_en, inbuff_rd_en, bm_rd_en, bm_rd_addr, eng_calc_en, eng_hold, eng_rstn,
                 outbuff_wr_en, busy, done, cfg_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle 0 is the cycle in which start is sampled; stops after done or after cycle 'stop'
  task automatic run(input int k, input int m, input int n, input int ef, input int el,
                     input int f1, input int f1l, input int f2, input int f2l, input int stop);
    r_bm = 0; r_wr = 0; r_fw = -1; r_lw = -1; r_dc = -1; r_aerr = 0; r_herr = 0; r_serr = 0; r_np = 0;
    for (int i = 0; i < 8; i++) r_pc[i] = -1;
    @(posedge clk); #1;
    cfg_k = 8'(k); cfg_m = 8'(m); cfg_beats = 16'(n);
    for (int c = 0; c <= stop && r_dc < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start = c == 0;
      inbuff_empty = c >= ef && c < ef + el;
      outbuff_full = (c >= f1 && c < f1 + f1l) || (c >= f2 && c < f2 + f2l);
      @(negedge clk);
      if (bm_rd_en) begin
        if (int'(bm_rd_addr) != r_bm % m) r_aerr++;
        r_bm++;
      end
      if (outbuff_wr_en) begin
        if (r_fw < 0) r_fw = c;
        r_lw = c;
        r_wr++;
      end
      if (inbuff_rd_en) begin
        if (r_np < 8) r_pc[r_np] = c;
        r_np++;
      end
      if (outbuff_full && (eng_hold !== 1'b1 || outbuff_wr_en || bm_rd_en)) r_herr++;
      if (inbuff_empty && (bm_rd_en || inbuff_rd_en)) r_serr++;
      if (done) r_dc = c;
    end
    start = 1'b0; inbuff_empty = 1'b0; outbuff_full = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL reset_outs got %h exp %h", outs, RST_OUTS); end
  endtask

  task automatic test_nominal;
    int exp_pc [5] = '{2, 5, 8, 11, 14};
    run(4, 3, 5, -1, 0, -1, 0, -1, 0, 400);
    checks++;
    if (r_bm !== 15) begin errors++; $display("FAIL nominal_bm_count got %0d exp 15", r_bm); end
    checks++;
    if (r_aerr !== 0) begin errors++; $display("FAIL nominal_addr_seq got %0d bad exp 0", r_aerr); end
    checks++;
    if (r_np !== 5) begin errors++; $display("FAIL nominal_pops got %0d exp 5", r_np); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (r_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL nominal_pop%0d_cycle got %0d exp %0d", i, r_pc[i], exp_pc[i]); end
    end
    checks++;
    if (r_wr !== 15) begin errors++; $display("FAIL nominal_writes got %0d exp 15", r_wr); end
    checks++;
    if (r_fw !== 5 || r_lw !== 19) begin errors++; $display("FAIL nominal_write_span got %0d..%0d exp 5..19", r_fw, r_lw); end
    checks++;
    if (r_dc !== 20) begin errors++; $display("FAIL nominal_done got %0d exp 20", r_dc); end
  endtask

  task automatic test_starvation;
    int exp_pc [5] = '{2, 9, 12, 15, 18};
    run(4, 3, 5, 5, 4, -1, 0, -1, 0, 400);
    checks++;
    if (r_serr !== 0) begin errors++; $display("FAIL starve_strobes got %0d exp 0", r_serr); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (r_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL starve_pop%0d_cycle got %0d exp %0d", i, r_pc[i], exp_pc[i]); end
    end
    checks++;
    if (r_wr !== 15 || r_bm !== 15) begin errors++; $display("FAIL starve_counts got wr %0d bm %0d exp 15 15", r_wr, r_bm); end
    checks++;
    if (r_dc !== 24) begin errors++; $display("FAIL starve_done got %0d exp 24", r_dc); end
  endtask

  task automatic test_backpressure;
    run(4, 3, 5, -1, 0, 8, 2, 20, 1, 400);
    checks++;
    if (r_herr !== 0) begin errors++; $display("FAIL bp_hold_cycles got %0d bad exp 0", r_herr); end
    checks++;
    if (r_wr !== 15 || r_bm !== 15 || r_aerr !== 0) begin errors++; $display("FAIL bp_counts got wr %0d bm %0d aerr %0d exp 15 15 0", r_wr, r_bm, r_aerr); end
    checks++;
    if (r_lw !== 22) begin errors++; $display("FAIL bp_last_write got %0d exp 22", r_lw); end
    checks++;
    if (r_dc !== 23) begin errors++; $display("FAIL bp_done got %0d exp 23", r_dc); end
  endtask

  task automatic test_boundary;
    run(2, 2, 1, -1, 0, -1, 0, -1, 0, 400);
    checks++;
    if (r_dc !== 7 || r_wr !== 2 || r_np !== 1) begin errors++; $display("FAIL min_cfg got done %0d wr %0d pops %0d exp 7 2 1", r_dc, r_wr, r_np); end
    run(128, 128, 1, -1, 0, -1, 0, -1, 0, 400);
    checks++;
    if (r_dc !== 133 || r_bm !== 128 || r_aerr !== 0) begin errors++; $display("FAIL max_cfg got done %0d bm %0d aerr %0d exp 133 128 0", r_dc, r_bm, r_aerr); end
  endtask

  task automatic test_illegal;
    int ks [3] = '{4, 129, 4};
    int ms [3] = '{1, 3, 3};
    int ns [3] = '{5, 5, 0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cfg_k = 8'(ks[i]); cfg_m = 8'(ms[i]); cfg_beats = 16'(ns[i]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || cfg_wr_en !== 1'b1) begin
        errors++; $display("FAIL illegal%0d_pulse got err %b busy %b wr %b exp 1 0 1", i, cfg_err, busy, cfg_wr_en);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL illegal%0d_after got err %b busy %b exp 0 0", i, cfg_err, busy); end
    end
  endtask

  task automatic test_abort;
    int bad = 0;
    run(4, 3, 5, -1, 0, -1, 0, -1, 0, 5);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_rstn !== 1'b0) begin errors++; $display("FAIL abort_eng_rstn got %b exp 0", eng_rstn); end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL abort_idle_outs got %h exp %h", outs, RST_OUTS); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (outbuff_wr_en || done || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_quiet got %0d bad cycles exp 0", bad); end
    run(4, 3, 5, -1, 0, -1, 0, -1, 0, 400);
    checks++;
    if (r_dc !== 20 || r_wr !== 15) begin errors++; $display("FAIL abort_restart got done %0d wr %0d exp 20 15", r_dc, r_wr); end
    @(posedge clk); #1;
    cfg_k = 8'd4; cfg_m = 8'd3; cfg_beats = 16'd5; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL start_abort_idle got busy %b err %b exp 0 0", busy, cfg_err); end
  endtask

  task automatic test_async_reset;
    run(4, 3, 5, -1, 0, -1, 0, -1, 0, 17);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b exp 1", busy); end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL async_reset_outs got %h exp %h", outs, RST_OUTS); end
    @(posedge clk); #1;
    rstn = 1'b1;
    run(4, 3, 5, -1, 0, -1, 0, -1, 0, 400);
    checks++;
    if (r_dc !== 20 || r_wr !== 15) begin errors++; $display("FAIL reset_rerun got done %0d wr %0d exp 20 15", r_dc, r_wr); end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; inbuff_empty = 1'b0; outbuff_full = 1'b0;
    cfg_k = 8'd4; cfg_m = 8'd3; cfg_beats = 16'd5;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    test_nominal();
    test_starvation();
    test_backpressure();
    test_boundary();
    test_illegal();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
